sysbus_mem_responder: RTL and testbench

- Target-side (responder) end of the system bus that the CPU core drives as initiator from its fetch and memory stages.
- Accepts 64-byte line read and write bursts from the bus and serves them from an internal word-addressed backing store.
- Returns read data as 8 response beats with the request tag echoed.
- Used as the memory model in core-level benches and as the on-chip scratch memory target behind the bus.

---
 rtl/sysbus_mem_responder.sv | 195 +++++++++++++++++++
 tb/tb_sysbus_mem_responder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : sysbus_mem_responder
// Brief    : System-bus responder serving 64-byte line read/write bursts from
//            an internal word-addressed backing store. Reads return 8 beats
//            with the request tag echoed; non-memory requests are dropped
//            and counted.
// Revision : 1.0 - initial release
// ============================================================================
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int RD_LATENCY     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  output logic                      bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_respcyc,
  input  logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic [15:0]               err_count
);

  // Word-index width and line-index width (a line is 8 consecutive words).
  // MEM_WORDS must be a power of two of at least 16.
  localparam int          c_aw        = $clog2(MEM_WORDS);
  localparam int          c_lw        = c_aw - 3;
  localparam logic [3:0]  c_lat_init  = 4'(RD_LATENCY - 1);
  localparam logic [2:0]  c_last_beat = 3'd7;
  localparam logic [3:0]  c_type_mem  = 4'b0001;
  localparam logic [15:0] c_err_max   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_DATA = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_RESP = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;

  logic [BUS_DATA_WIDTH-1:0]   r_mem [MEM_WORDS];

  logic [c_lw-1:0]             r_line;
  logic [BUS_TAG_WIDTH-1:0]    r_tag;
  logic [2:0]                  r_beat;
  logic [3:0]                  r_lat;
  logic                        r_respcyc;
  logic [BUS_DATA_WIDTH-1:0]   r_resp;
  logic [BUS_TAG_WIDTH-1:0]    r_resptag;
  logic [15:0]                 r_err;

  logic                        w_reqack;
  logic                        w_req_xfer;
  logic                        w_resp_xfer;
  logic                        w_is_mem;
  logic                        w_is_read;
  logic [c_lw-1:0]             w_line_in;
  logic [2:0]                  w_beat_inc;

  // Request acceptance is purely combinational so the initiator sees the
  // ack in the same cycle it raises reqcyc; it is suppressed during reset.
  assign w_reqack    = bus_reqcyc && reset &&
                       ((r_state == ST_IDLE) || (r_state == ST_WR_DATA));
  assign w_req_xfer  = bus_reqcyc && w_reqack;
  assign w_resp_xfer = r_respcyc && bus_respack;

  // Address-beat decode. Byte address -> word index -> line index; the low
  // three word-index bits are the beat number, and bits above the store
  // depth are simply dropped (aliasing, no error).
  assign w_is_mem   = (bus_reqtag[BUS_TAG_WIDTH-2 -: 4] == c_type_mem);
  assign w_is_read  = bus_reqtag[BUS_TAG_WIDTH-1];
  assign w_line_in  = bus_req[c_aw+2:6];
  assign w_beat_inc = r_beat + 3'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req_xfer && w_is_mem) begin
          w_state_nxt = w_is_read ? ST_RD_WAIT : ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (w_req_xfer && (r_beat == c_last_beat)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (r_lat == 4'd0) begin
          w_state_nxt = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (w_resp_xfer && (r_beat == c_last_beat)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Burst bookkeeping, response beat register and error counter. Each read
  // beat is fetched from the store at the edge it becomes visible, so data
  // always reflects the store as of the presentation cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_line    <= '0;
      r_tag     <= '0;
      r_beat    <= 3'd0;
      r_lat     <= 4'd0;
      r_respcyc <= 1'b0;
      r_resp    <= '0;
      r_resptag <= '0;
      r_err     <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_xfer) begin
            r_tag  <= bus_reqtag;
            r_line <= w_line_in;
            if (!w_is_mem) begin
              if (r_err != c_err_max) begin
                r_err <= r_err + 16'd1;
              end
            end else if (w_is_read) begin
              r_lat <= c_lat_init;
            end else begin
              r_beat <= 3'd0;
            end
          end
        end
        ST_WR_DATA: begin
          if (w_req_xfer) begin
            r_beat <= w_beat_inc;
          end
        end
        ST_RD_WAIT: begin
          if (r_lat == 4'd0) begin
            r_respcyc <= 1'b1;
            r_resp    <= r_mem[{r_line, 3'd0}];
            r_resptag <= r_tag;
            r_beat    <= 3'd0;
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        ST_RD_RESP: begin
          if (w_resp_xfer) begin
            if (r_beat == c_last_beat) begin
              r_respcyc <= 1'b0;
            end else begin
              r_beat <= w_beat_inc;
              r_resp <= r_mem[{r_line, w_beat_inc}];
            end
          end
        end
        default: begin
          r_respcyc <= 1'b0;
        end
      endcase
    end
  end

  // Backing store write port; contents survive reset by design.
  always_ff @(posedge clk) begin
    if ((r_state == ST_WR_DATA) && w_req_xfer) begin
      r_mem[{r_line, r_beat}] <= bus_req;
    end
  end

  assign bus_reqack  = w_reqack;
  assign bus_respcyc = r_respcyc;
  assign bus_resp    = r_resp;
  assign bus_resptag = r_resptag;
  assign err_count   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sysbus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sysbus_mem_responder
// Brief    : Self-checking bench for sysbus_mem_responder: directed vector
//            table, randomized traffic against a line-level memory model,
//            error-counter saturation and reset-during-read sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sysbus_mem_responder;

  localparam int MEM_WORDS  = 4096;
  localparam int RD_LATENCY = 4;
  localparam int NV         = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_reqcyc;
  logic        bus_reqack;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_respcyc;
  logic        bus_respack;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mdl     [MEM_WORDS];
  bit          line_ok [MEM_WORDS/8];
  logic [63:0] beat_buf [8];
  logic [63:0] exp_buf  [8];
  logic [15:0] exp_err = 16'd0;

  typedef struct {
    int          kind;     // 0 write burst, 1 read burst, 2 non-memory request
    logic [63:0] addr;
    logic [12:0] tag;
    logic [63:0] d0;       // first data word written / expected; beat i = d0+i
    int          mode;     // read ack pattern: 0 always, 1 toggle, 2 random
    logic [15:0] exp_err;
  } vec_t;

  vec_t vecs [NV];

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH(64),
    .BUS_TAG_WIDTH (13),
    .MEM_WORDS     (MEM_WORDS),
    .RD_LATENCY    (RD_LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_reqcyc (bus_reqcyc),
    .bus_reqack (bus_reqack),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_respcyc(bus_respcyc),
    .bus_respack(bus_respack),
    .bus_resp   (bus_resp),
    .bus_resptag(bus_resptag),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Word index of beat i for a byte address: line-aligned, modulo store depth.
  function automatic int unsigned widx(input logic [63:0] addr, input int i);
    longint unsigned w;
    w = addr >> 3;
    w = w - (w % 8);
    return int'((w + longint'(i)) % MEM_WORDS);
  endfunction

  // Write burst of beat_buf[0..7]; optional idle gaps between data beats.
  task automatic do_write(input logic [63:0] addr, input logic [12:0] tag, input bit gaps);
    bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag;
    #1 chk("wr_addr_ack", 64'(bus_reqack), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        bus_reqcyc = 1'b0;
        #1 chk("wr_gap_noack", 64'(bus_reqack), 64'd0);
        @(negedge clk);
      end
      bus_reqcyc = 1'b1; bus_req = beat_buf[i]; bus_reqtag = 13'($urandom);
      #1 chk("wr_data_ack", 64'(bus_reqack), 64'd1);
    end
    @(negedge clk);
    bus_reqcyc = 1'b0;
    #1 chk("wr_no_resp", 64'(bus_respcyc), 64'd0);
    for (int i = 0; i < 8; i++) mdl[widx(addr, i)] = beat_buf[i];
    line_ok[widx(addr, 0) / 8] = 1'b1;
  endtask

  // Read burst checked against exp_buf[0..7] with the chosen ack pattern.
  task automatic do_read(input logic [63:0] addr, input logic [12:0] tag, input int mode);
    int lat;
    int i;
    int guard;
    bit ack;
    bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag;
    #1 chk("rd_addr_ack", 64'(bus_reqack), 64'd1);
    @(negedge clk);
    // keep offering a request; it must not be accepted until the burst ends
    bus_reqtag = 13'h1201;
    #1;
    lat = 0;
    while (!bus_respcyc && lat < 40) begin
      chk("rd_wait_noack", 64'(bus_reqack), 64'd0);
      @(negedge clk); #1;
      lat++;
    end
    chk("rd_latency", 64'(lat), 64'(RD_LATENCY));
    if (!bus_respcyc) begin
      bus_reqcyc = 1'b0;
      return;
    end
    i = 0; guard = 0;
    while (i < 8 && guard < 64) begin
      chk("rd_respcyc", 64'(bus_respcyc), 64'd1);
      chk("rd_data", bus_resp, exp_buf[i]);
      chk("rd_tag", 64'(bus_resptag), 64'(tag));
      chk("rd_busy_noack", 64'(bus_reqack), 64'd0);
      case (mode)
        0:       ack = 1'b1;
        1:       ack = (guard % 2) == 0;
        default: ack = 1'($urandom_range(0, 1));
      endcase
      bus_respack = ack;
      @(negedge clk); #1;
      if (ack) i++;
      guard++;
    end
    bus_respack = 1'b0;
    bus_reqcyc  = 1'b0;
    chk("rd_beats_done", 64'(i), 64'd8);
    chk("rd_end_respcyc", 64'(bus_respcyc), 64'd0);
    chk("rd_end_hold_data", bus_resp, exp_buf[7]);
    chk("rd_end_hold_tag", 64'(bus_resptag), 64'(tag));
  endtask

  // Non-memory request: acked, dropped, no response, counter bumps.
  task automatic do_nonmem(input logic [63:0] addr, input logic [12:0] tag);
    bit seen;
    bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag;
    #1 chk("nm_ack", 64'(bus_reqack), 64'd1);
    @(negedge clk);
    bus_reqcyc = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < RD_LATENCY + 4; k++) begin
      @(negedge clk);
      if (bus_respcyc) seen = 1'b1;
    end
    chk("nm_no_resp", 64'(seen), 64'd0);
  endtask

  initial begin
    int          lat;
    logic [63:0] a;
    logic [3:0]  ty;
    int unsigned lines [8];
    int unsigned ln;

    vecs[0]  = '{0, 64'h1000, 13'h0101, 64'hA0, 0, 16'd0};
    vecs[1]  = '{1, 64'h1000, 13'h1101, 64'hA0, 0, 16'd0};
    vecs[2]  = '{1, 64'h1000, 13'h1101, 64'hA0, 1, 16'd0};
    vecs[3]  = '{0, 64'h7FF8, 13'h0102, 64'hB0, 0, 16'd0};
    vecs[4]  = '{1, 64'h7FC0, 13'h1102, 64'hB0, 0, 16'd0};
    vecs[5]  = '{1, 64'hFFF8, 13'h1103, 64'hB0, 1, 16'd0};
    vecs[6]  = '{0, 64'h8000, 13'h0103, 64'hC0, 0, 16'd0};
    vecs[7]  = '{1, 64'h0000, 13'h1104, 64'hC0, 2, 16'd0};
    vecs[8]  = '{1, 64'h1038, 13'h11FF, 64'hA0, 0, 16'd0};
    vecs[9]  = '{2, 64'h1000, 13'h1201, 64'h0,  0, 16'd1};
    vecs[10] = '{2, 64'h0000, 13'h0F01, 64'h0,  0, 16'd2};
    vecs[11] = '{1, 64'h1000, 13'h1101, 64'hA0, 0, 16'd2};
    vecs[12] = '{2, 64'h7FC0, 13'h1001, 64'h0,  0, 16'd3};
    vecs[13] = '{0, 64'h1000, 13'h0105, 64'hD0, 0, 16'd3};
    vecs[14] = '{1, 64'h1000, 13'h1106, 64'hD0, 2, 16'd3};
    vecs[15] = '{1, 64'hFFFF_0000_0000_7FC0, 13'h1107, 64'hB0, 0, 16'd3};

    reset = 1'b0; bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; bus_respack = 1'b0;
    repeat (3) @(negedge clk);
    bus_reqcyc = 1'b1;
    #1 chk("rst_ack_low", 64'(bus_reqack), 64'd0);
    bus_reqcyc = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_respcyc", 64'(bus_respcyc), 64'd0);
    chk("rst_reqack", 64'(bus_reqack), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_resp", bus_resp, 64'd0);
    chk("rst_resptag", 64'(bus_resptag), 64'd0);

    // Directed vector table.
    for (int v = 0; v < NV; v++) begin
      case (vecs[v].kind)
        0: begin
          for (int i = 0; i < 8; i++) beat_buf[i] = vecs[v].d0 + 64'(i);
          do_write(vecs[v].addr, vecs[v].tag, 1'b0);
        end
        1: begin
          for (int i = 0; i < 8; i++) exp_buf[i] = vecs[v].d0 + 64'(i);
          do_read(vecs[v].addr, vecs[v].tag, vecs[v].mode);
        end
        default: do_nonmem(vecs[v].addr, vecs[v].tag);
      endcase
      chk("vec_err_count", 64'(err_count), 64'(vecs[v].exp_err));
    end
    exp_err = 16'd3;

    // Randomized traffic over a small working set of lines, checked against
    // the array model; addresses carry random in-line offsets and high bits.
    for (int k = 0; k < 8; k++) lines[k] = $urandom_range(0, MEM_WORDS/8 - 1);
    for (int n = 0; n < 40; n++) begin
      ln = lines[$urandom_range(0, 7)];
      a  = 64'(ln) * 64 + 64'($urandom_range(0, 63))
         + 64'($urandom_range(0, 3)) * 64'(MEM_WORDS * 8)
         + {32'($urandom_range(0, 3)), 32'h0};
      if ($urandom_range(0, 9) == 0) begin
        ty = 4'($urandom_range(2, 15));
        do_nonmem(a, {1'($urandom_range(0, 1)), ty, 8'($urandom)});
        exp_err = exp_err + 16'd1;
      end else if (!line_ok[ln] || $urandom_range(0, 2) == 0) begin
        for (int i = 0; i < 8; i++) beat_buf[i] = {$urandom, $urandom};
        do_write(a, {1'b0, 4'b0001, 8'($urandom)}, 1'b1);
      end else begin
        for (int i = 0; i < 8; i++) exp_buf[i] = mdl[widx(a, i)];
        do_read(a, {1'b1, 4'b0001, 8'($urandom)}, int'($urandom_range(0, 2)));
      end
      chk("rnd_err_count", 64'(err_count), 64'(exp_err));
    end

    // Error counter saturation: 65536 back-to-back non-memory requests.
    bus_reqcyc = 1'b1; bus_req = 64'h40; bus_reqtag = 13'h1201;
    repeat (65536) @(negedge clk);
    #1 chk("sat_err", 64'(err_count), 64'hFFFF);
    @(negedge clk);
    bus_reqcyc = 1'b0;
    #1 chk("sat_hold", 64'(err_count), 64'hFFFF);

    // Reset after read beat 3 is acked.
    for (int i = 0; i < 8; i++) exp_buf[i] = mdl[widx(64'h1000, i)];
    bus_reqcyc = 1'b1; bus_req = 64'h1000; bus_reqtag = 13'h1107;
    #1 chk("mid_addr_ack", 64'(bus_reqack), 64'd1);
    @(negedge clk);
    bus_reqcyc = 1'b0;
    lat = 0;
    while (!bus_respcyc && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("mid_latency", 64'(lat), 64'(RD_LATENCY));
    for (int i = 0; i < 4; i++) begin
      chk("mid_data", bus_resp, exp_buf[i]);
      bus_respack = 1'b1;
      @(negedge clk);
    end
    chk("mid_beat4", bus_resp, exp_buf[4]);
    bus_respack = 1'b0;
    reset = 1'b0;
    bus_reqcyc = 1'b1; bus_req = 64'h7FC0; bus_reqtag = 13'h1108;
    #1 chk("mid_rst_noack", 64'(bus_reqack), 64'd0);
    @(negedge clk); #1;
    chk("mid_rst_respcyc", 64'(bus_respcyc), 64'd0);
    chk("mid_rst_resp", bus_resp, 64'd0);
    chk("mid_rst_tag", 64'(bus_resptag), 64'd0);
    chk("mid_rst_err", 64'(err_count), 64'd0);
    reset = 1'b1;
    bus_reqcyc = 1'b0;
    for (int i = 0; i < 8; i++) exp_buf[i] = mdl[widx(64'h7FC0, i)];
    do_read(64'h7FC0, 13'h1108, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
